// File: rtl/dbus_mem_responder_if.sv
// rtl/dbus_mem_responder_if.sv - CPU data-bus request/response signal bundle.
interface dbus_mem_responder_if #(
  parameter int DBUS_AW   = 8,
  parameter int DBUS_DW   = 32,
  parameter int DBUS_ISEL = DBUS_DW / 8
);
  logic                 req_m2dbiu;
  logic [DBUS_AW-1:0]   adr_m2dbiu;
  logic [DBUS_DW-1:0]   dat_m2dbiu;
  logic                 we_m2dbiu;
  logic [DBUS_ISEL-1:0] sel_m2dbiu;
  logic [DBUS_DW-1:0]   dat_dbiu2m;
  logic                 ack_dbiu2m;

  modport master (
    output req_m2dbiu, adr_m2dbiu, dat_m2dbiu, we_m2dbiu, sel_m2dbiu,
    input  dat_dbiu2m, ack_dbiu2m
  );

  modport slave (
    input  req_m2dbiu, adr_m2dbiu, dat_m2dbiu, we_m2dbiu, sel_m2dbiu,
    output dat_dbiu2m, ack_dbiu2m
  );
endinterface

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - Wait-state register-file slave on the CPU data bus.
module dbus_mem_responder #(
  parameter int          DBUS_AW     = 8,
  parameter int          DBUS_DW     = 32,
  parameter int          DBUS_ISEL   = DBUS_DW / 8,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] INIT_BASE   = 32'hC0DE_0000
) (
  input  logic                       clk,
  input  logic                       resetn,
  dbus_mem_responder_if.slave        bus,
  output logic                       busy
);
  localparam int OFS = $clog2(DBUS_ISEL);
  localparam int IW  = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic [IW-1:0]        cap_idx;
  logic [DBUS_DW-1:0]   cap_dat;
  logic                 cap_we;
  logic [DBUS_ISEL-1:0] cap_sel;
  logic [DBUS_DW-1:0]   rdat;
  logic                 ack;
  logic [DBUS_DW-1:0]   lane_mask;
  logic                 access;
  logic                 wr_en;
  logic [DBUS_DW-1:0]   mem_q [DEPTH_WORDS];

  // Offset and upper address bits are deliberately dropped so addresses alias.
  logic unused_adr;
  assign unused_adr = ^bus.adr_m2dbiu;

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < DBUS_ISEL; b++) begin
      lane_mask[8*b +: 8] = {8{cap_sel[b]}};
    end
  end

  assign access = (state == ST_WAIT) && bus.req_m2dbiu && (cnt == 4'd0);
  assign wr_en  = access && cap_we;

  for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
    logic [DBUS_DW-1:0] word;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        word <= DBUS_DW'(INIT_BASE + 32'(w));
      end else if (wr_en && (cap_idx == IW'(w))) begin
        word <= (word & ~lane_mask) | (cap_dat & lane_mask);
      end
    end
    assign mem_q[w] = word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      cap_idx <= '0;
      cap_dat <= '0;
      cap_we  <= 1'b0;
      cap_sel <= '0;
      rdat    <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack  <= 1'b0;
      rdat <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.req_m2dbiu) begin
            cap_idx <= bus.adr_m2dbiu[OFS +: IW];
            cap_dat <= bus.dat_m2dbiu;
            cap_we  <= bus.we_m2dbiu;
            cap_sel <= bus.sel_m2dbiu;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= ST_WAIT;
            busy    <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A dropped request is an abort and takes priority over completion.
          if (!bus.req_m2dbiu) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_ACK;
            ack   <= 1'b1;
            if (!cap_we) begin
              rdat <= mem_q[cap_idx] & lane_mask;
            end
          end
        end
        ST_ACK: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_dbiu2m = ack;
  assign bus.dat_dbiu2m = rdat;
endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - Self-checking bench for dbus_mem_responder.
module tb_dbus_mem_responder;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  int checks = 0;
  int errors = 0;

  dbus_mem_responder_if #(.DBUS_AW(8), .DBUS_DW(32)) bus ();

  dbus_mem_responder #(
    .DBUS_AW(8), .DBUS_DW(32), .DBUS_ISEL(4), .DEPTH_WORDS(64),
    .WAIT_CYCLES(WAIT_CYCLES), .INIT_BASE(32'hC0DE_0000)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference memory: plain word array updated with byte-mask arithmetic.
  logic [31:0] ref_mem [64];

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [31:0] model_access(input logic w, input logic [31:0] a,
                                               input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'((a % 256) / 4) % 64;
    if (w) begin
      ref_mem[idx] = (ref_mem[idx] & ~lanes(s)) | (d & lanes(s));
      return 32'h0;
    end
    return ref_mem[idx] & lanes(s);
  endfunction

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.req_m2dbiu = 1'b1;
    bus.we_m2dbiu  = w;
    bus.adr_m2dbiu = a[7:0];
    bus.dat_m2dbiu = d;
    bus.sel_m2dbiu = s;
  endtask

  // Starts from IDLE, leaves the DUT back in IDLE with req low.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int lat;
    int busy_lo;
    drive(w, a, d, s);
    @(posedge clk); #1;
    lat = 0;
    busy_lo = 0;
    bus.adr_m2dbiu = 8'($urandom);
    bus.dat_m2dbiu = $urandom;
    bus.sel_m2dbiu = 4'($urandom);
    bus.we_m2dbiu  = 1'($urandom);
    while (!bus.ack_dbiu2m && lat < 40) begin
      if (!busy) busy_lo++;
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.dat_dbiu2m;
    chk("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    chk("busy_in_wait", 32'(busy_lo), 32'd0);
    bus.req_m2dbiu = 1'b0;
    @(posedge clk); #1;
    chk("ack_width", 32'(bus.ack_dbiu2m), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_dat", bus.dat_dbiu2m, 32'd0);
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];
  logic [31:0] rd;
  logic [31:0] exp_v;
  int ack_t[$];
  int nack;

  initial begin
    vt[0] = '{1'b0, 32'h00,  32'h0,         4'hF,    32'hC0DE_0000};
    vt[1] = '{1'b1, 32'h04,  32'h1122_3344, 4'b0101, 32'h0};
    vt[2] = '{1'b0, 32'h04,  32'h0,         4'hF,    32'hC022_0044};
    vt[3] = '{1'b0, 32'h100, 32'h0,         4'b1100, 32'hC0DE_0000};
    vt[4] = '{1'b0, 32'h08,  32'h0,         4'b0011, 32'h0000_0002};
    vt[5] = '{1'b0, 32'hFC,  32'h0,         4'hF,    32'hC0DE_003F};
    vt[6] = '{1'b1, 32'h14,  32'hAABB_CCDD, 4'h0,    32'h0};
    vt[7] = '{1'b0, 32'h14,  32'h0,         4'hF,    32'hC0DE_0005};
    vt[8] = '{1'b0, 32'h14,  32'h0,         4'h0,    32'h0};

    bus.req_m2dbiu = 1'b0;
    bus.we_m2dbiu  = 1'b0;
    bus.adr_m2dbiu = 8'h0;
    bus.dat_m2dbiu = 32'h0;
    bus.sel_m2dbiu = 4'h0;
    model_reset();
    #2;
    chk("reset_ack", 32'(bus.ack_dbiu2m), 32'd0);
    chk("reset_dat", bus.dat_dbiu2m, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      txn(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd);
      void'(model_access(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel));
      chk($sformatf("vec%0d", i), rd, vt[i].exp);
    end

    // Request held high: acks must repeat every WAIT_CYCLES+4 edges, never from DONE.
    exp_v = model_access(1'b0, 32'h20, 32'h0, 4'hF);
    drive(1'b0, 32'h20, 32'h0, 4'hF);
    @(posedge clk); #1;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      if (bus.ack_dbiu2m) begin
        ack_t.push_back(t);
        chk("b2b_dat", bus.dat_dbiu2m, exp_v);
      end
    end
    bus.req_m2dbiu = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ack_count", 32'(ack_t.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (ack_t.size() > k)
        chk($sformatf("b2b_ack_pos%0d", k), 32'(ack_t[k]), 32'(WAIT_CYCLES + 1 + k * (WAIT_CYCLES + 4)));
    end
    chk("b2b_abort_busy", 32'(busy), 32'd0);

    // Abort: store dropped one cycle after capture must neither ack nor write.
    drive(1'b1, 32'h0C, 32'h5566_7788, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_m2dbiu = 1'b0;
    nack = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (bus.ack_dbiu2m) nack++;
    end
    chk("abort_no_ack", 32'(nack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    txn(1'b0, 32'h0C, 32'h0, 4'hF, rd);
    chk("abort_readback", rd, 32'hC0DE_0003);

    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255);
      d = $urandom;
      s = 4'($urandom);
      exp_v = model_access(w, a, d, s);
      txn(w, a, d, s, rd);
      chk($sformatf("rand%0d", i), rd, exp_v);
    end

    // Asynchronous reset during the WAIT of a store.
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_ack", 32'(bus.ack_dbiu2m), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dat", bus.dat_dbiu2m, 32'd0);
    bus.req_m2dbiu = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd);
    chk("rst_readback", rd, 32'hC0DE_0004);
    exp_v = model_access(1'b0, 32'h04, 32'h0, 4'hF);
    txn(1'b0, 32'h04, 32'h0, 4'hF, rd);
    chk("rst_restore", rd, exp_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
